aes_key_sched_ctrl: RTL and testbench
=====================================

AES_KEY_SCHED_CTRL -- requirements
Module: aes_key_sched_ctrl

Interface
REQ-001 Parameter: NR, default 10, number of AES-128 rounds; 10 is the only supported value.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 key_valid  input  1  cipher key offered on key_in.
REQ-005 key_ready  output  1  controller can accept a key.
REQ-006 key_in  input  128  cipher key, word w0 = [127:96].
REQ-007 sw_out  output  32  word sent to the external 4-byte S-box unit.
REQ-008 sw_in  input  32  bytewise S-box of sw_out, returned combinationally in the same cycle.
REQ-009 rk_req  input  1  round-key read request.
REQ-010 rk_idx  input  4  requested round-key index, 0..10.
REQ-011 rk_valid  output  1  one-cycle pulse; rk_data/rk_err are valid.
REQ-012 rk_data  output  128  requested round key.
REQ-013 rk_err  output  1  with rk_valid: rk_idx was out of range.
REQ-014 busy  output  1  expansion in progress.
REQ-015 keys_ready  output  1  all 11 round keys are stored and readable.

Function
REQ-016 The FSM SHALL have three states, IDLE, EXPAND and READY; key_ready SHALL be 1 in IDLE and READY and 0 in EXPAND; busy SHALL be 1 only in EXPAND; keys_ready SHALL be 1 only in READY.
REQ-017 Key acceptance SHALL occur on a cycle with key_valid && key_ready: key_in is written to rk[0], the round counter r is set to 1, rcon is set to 8'h01, and the next state is EXPAND.
REQ-018 In EXPAND, sw_out SHALL be RotWord(w3 of rk[r-1]), i.e. {w3[23:0], w3[31:24]}; in other states sw_out SHALL be 0.
REQ-019 Each EXPAND cycle SHALL write rk[r] per FIPS-197:
- t = sw_in ^ {rcon, 24'h0};
- w4 = w0^t, w5 = w1^w4, w6 = w2^w5, w7 = w3^w6 (w0..w3 taken from rk[r-1]).
REQ-020 After each EXPAND cycle, rcon SHALL update by xtime: shift left, and XOR 8'h1b if bit 7 was set (sequence 01,02,04,08,10,20,40,80,1b,36); r SHALL increment.
REQ-021 The write of rk[10] SHALL move the FSM to READY; expansion takes exactly 10 cycles, so keys_ready rises 11 cycles after the acceptance edge.
REQ-022 key_valid in EXPAND SHALL be ignored, with no effect on state or storage.
REQ-023 A key accepted in READY SHALL restart expansion; keys_ready SHALL drop on the next cycle.
REQ-024 rk_req SHALL be serviced only in READY; requests in IDLE or EXPAND SHALL be dropped with no rk_valid, and the requester must re-issue.
REQ-025 A serviced request SHALL produce rk_valid exactly 1 cycle later with registered rk_data = rk[rk_idx] and rk_err = 0.
REQ-026 A serviced request with rk_idx > 10 SHALL produce rk_valid = 1, rk_err = 1 and rk_data = 0.
REQ-027 Back-to-back rk_req on consecutive cycles SHALL each be serviced, giving one rk_valid per cycle.
REQ-028 A request serviced on the same edge as a new key acceptance SHALL return the pre-acceptance contents, including the old rk[0].
REQ-029 rk_valid and rk_err SHALL be 0 on every cycle without a serviced request; rk_data SHALL hold its last value.

Reset
REQ-030 While rst_n = 0, the following SHALL be cleared immediately:
- state = IDLE, r = 0, rcon = 8'h01;
- all rk[0..10] = 0;
- rk_valid = 0, rk_err = 0, rk_data = 0;
- busy = 0, keys_ready = 0, sw_out = 0;
- key_ready = 1.
REQ-031 Reset asserted mid-expansion SHALL abort the expansion; after release the block SHALL be in IDLE and need a fresh key.

Verification
REQ-032 The bench SHALL model the S-box on sw_out -> sw_in and cover these scenarios:
- FIPS-197 vector: load key 2b7e151628aed2a6abf7158809cf4f3c -> rk[1] = a0fafe1788542cb123a339392a6c7605, rk[10] = d014f9a8c9ee2589e13f0cc8b6630ca6; keys_ready rises exactly 11 cycles after acceptance; busy is high for exactly 10 cycles.
- Read timing: in READY, rk_req with idx 0,1,...,10 on consecutive cycles -> 11 consecutive rk_valid pulses, each 1 cycle after its request, with correct data; idx 11 and idx 15 -> rk_valid = 1, rk_err = 1, rk_data = 0.
- Reload: key_valid during EXPAND with key 000102...0f -> ignored and FIPS result unchanged; the same key offered in READY -> rk[10] = 13111d7fe3944a17f307a78b4d2b30c5 after 11 cycles.
- Dropped request: rk_req during EXPAND -> no rk_valid.
- Same-edge collision: rk_req idx 0 on the key-accept edge -> returns the old key.
- Reset mid-expansion: rst_n low at expand cycle 5 -> all outputs at their reset values at once; after release a fresh load yields correct keys.

Source files
------------

// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key schedule controller: expands a cipher key into 11 round keys
// using an external 4-byte S-box unit, then serves registered round-key reads.
module aes_key_sched_ctrl #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_valid,
  output logic         key_ready,
  input  logic [127:0] key_in,
  output logic [31:0]  sw_out,
  input  logic [31:0]  sw_in,
  input  logic         rk_req,
  input  logic [3:0]   rk_idx,
  output logic         rk_valid,
  output logic [127:0] rk_data,
  output logic         rk_err,
  output logic         busy,
  output logic         keys_ready
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] EXPAND = 2'd1;
  localparam logic [1:0] READY  = 2'd2;

  localparam logic [3:0] LAST = 4'(NR);

  logic [1:0]   state;
  logic [3:0]   r;
  logic [7:0]   rcon;
  logic [127:0] rk [0:NR];

  logic [127:0] prev_key;
  logic [127:0] next_key;
  logic [127:0] read_word;
  logic [31:0]  t, w4, w5, w6, w7;
  logic [7:0]   rcon_next;
  logic         accept;

  assign key_ready  = (state != EXPAND);
  assign busy       = (state == EXPAND);
  assign keys_ready = (state == READY);
  assign accept     = key_valid && key_ready;

  // Loop-based selects keep every array index provably in range.
  always_comb begin
    prev_key  = '0;
    read_word = '0;
    for (int i = 0; i < NR; i++) begin
      if (r == 4'(i + 1)) prev_key = rk[i];
    end
    for (int i = 0; i <= NR; i++) begin
      if (rk_idx == 4'(i)) read_word = rk[i];
    end
  end

  always_comb begin
    sw_out    = (state == EXPAND) ? {prev_key[23:0], prev_key[31:24]} : 32'h0;
    t         = sw_in ^ {rcon, 24'h0};
    w4        = prev_key[127:96] ^ t;
    w5        = prev_key[95:64]  ^ w4;
    w6        = prev_key[63:32]  ^ w5;
    w7        = prev_key[31:0]   ^ w6;
    next_key  = {w4, w5, w6, w7};
    rcon_next = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      r        <= 4'd0;
      rcon     <= 8'h01;
      rk_valid <= 1'b0;
      rk_err   <= 1'b0;
      rk_data  <= '0;
      for (int i = 0; i <= NR; i++) rk[i] <= '0;
    end else begin
      rk_valid <= 1'b0;
      rk_err   <= 1'b0;
      // Reads sample the array before this edge's writes land, so a read on the
      // acceptance edge returns the previous key.
      if (state == READY && rk_req) begin
        rk_valid <= 1'b1;
        if (rk_idx > LAST) begin
          rk_err  <= 1'b1;
          rk_data <= '0;
        end else begin
          rk_data <= read_word;
        end
      end

      case (state)
        IDLE, READY: begin
          if (accept) begin
            rk[0] <= key_in;
            r     <= 4'd1;
            rcon  <= 8'h01;
            state <= EXPAND;
          end
        end
        EXPAND: begin
          for (int i = 1; i <= NR; i++) begin
            if (r == 4'(i)) rk[i] <= next_key;
          end
          rcon <= rcon_next;
          r    <= r + 4'd1;
          if (r == LAST) state <= READY;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Self-checking bench for aes_key_sched_ctrl: S-box model on sw_out->sw_in,
// word-level FIPS-197 reference expansion, table vectors and random keys.
module tb_aes_key_sched_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         key_valid;
  logic         key_ready;
  logic [127:0] key_in;
  logic [31:0]  sw_out;
  logic [31:0]  sw_in;
  logic         rk_req;
  logic [3:0]   rk_idx;
  logic         rk_valid;
  logic [127:0] rk_data;
  logic         rk_err;
  logic         busy;
  logic         keys_ready;

  int vectors    = 0;
  int miscompares = 0;

  logic [127:0] model_rk [0:10];

  localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] SEQ_KEY   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] SEQ_RK10  = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  typedef struct {
    logic [3:0]   idx;
    logic [127:0] data;
    logic         err;
  } vec_t;

  vec_t tbl [6];

  always #5 clk = ~clk;

  aes_key_sched_ctrl #(.NR(10)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .key_in     (key_in),
    .sw_out     (sw_out),
    .sw_in      (sw_in),
    .rk_req     (rk_req),
    .rk_idx     (rk_idx),
    .rk_valid   (rk_valid),
    .rk_data    (rk_data),
    .rk_err     (rk_err),
    .busy       (busy),
    .keys_ready (keys_ready)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  // S-box from its definition: inverse in GF(2^8) (x^254) then the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq, inv;
    sq = x; inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    if (x == 8'h00) inv = 8'h00;
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  assign sw_in = subword(sw_out);

  // Reference expansion over the 44-word schedule, as FIPS-197 writes it.
  task automatic computeModel(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] temp;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      temp = w[i-1];
      if (i % 4 == 0) begin
        temp = subword({temp[23:0], temp[31:24]}) ^ {rc, 24'h0};
        rc   = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ temp;
    end
    for (int j = 0; j <= 10; j++) model_rk[j] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
  endtask

  task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Drives one cycle of inputs, steps past the edge, then returns pulses to 0.
  task automatic applyStimulus(input logic kv, input logic [127:0] k, input logic rq, input logic [3:0] idx);
    key_valid = kv;
    key_in    = k;
    rk_req    = rq;
    rk_idx    = idx;
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    rk_req    = 1'b0;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_key_ready"},  128'(key_ready),  128'd1);
    checkOutput({tag, "_busy"},       128'(busy),       128'd0);
    checkOutput({tag, "_keys_ready"}, 128'(keys_ready), 128'd0);
    checkOutput({tag, "_rk_valid"},   128'(rk_valid),   128'd0);
    checkOutput({tag, "_rk_err"},     128'(rk_err),     128'd0);
    checkOutput({tag, "_rk_data"},    rk_data,          128'd0);
    checkOutput({tag, "_sw_out"},     128'(sw_out),     128'd0);
  endtask

  // Called right after the acceptance edge; lat counts the acceptance cycle as 1.
  task automatic waitReady(output int lat, output int busy_cnt);
    lat = 1;
    busy_cnt = 0;
    for (int n = 0; n < 40 && !keys_ready; n++) begin
      if (busy) busy_cnt++;
      lat++;
      applyStimulus(1'b0, '0, 1'b0, 4'd0);
    end
    if (!keys_ready) checkOutput("ready_timeout", 128'(keys_ready), 128'd1);
  endtask

  task automatic readCheck(input logic [3:0] idx, input string name);
    logic [127:0] exp_data;
    logic         exp_err;
    exp_err  = (idx > 4'd10);
    exp_data = exp_err ? '0 : model_rk[idx];
    applyStimulus(1'b0, '0, 1'b1, idx);
    checkOutput({name, "_valid"}, 128'(rk_valid), 128'd1);
    checkOutput({name, "_err"},   128'(rk_err),   128'(exp_err));
    checkOutput({name, "_data"},  rk_data,        exp_data);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int lat, bc;
    logic [127:0] rkey;

    tbl[0] = '{idx: 4'd0,  data: FIPS_KEY,  err: 1'b0};
    tbl[1] = '{idx: 4'd1,  data: FIPS_RK1,  err: 1'b0};
    tbl[2] = '{idx: 4'd10, data: FIPS_RK10, err: 1'b0};
    tbl[3] = '{idx: 4'd11, data: '0,        err: 1'b1};
    tbl[4] = '{idx: 4'd15, data: '0,        err: 1'b1};
    tbl[5] = '{idx: 4'd0,  data: FIPS_KEY,  err: 1'b0};

    rst_n = 1'b0; key_valid = 1'b0; key_in = '0; rk_req = 1'b0; rk_idx = 4'd0;
    #2;
    checkResetOutputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    applyStimulus(1'b0, '0, 1'b0, 4'd0);

    applyStimulus(1'b0, '0, 1'b1, 4'd0);
    checkOutput("idle_req_dropped", 128'(rk_valid), 128'd0);

    // FIPS load with an ignored key and a dropped read during expansion.
    computeModel(FIPS_KEY);
    checkOutput("model_rk1",  model_rk[1],  FIPS_RK1);
    checkOutput("model_rk10", model_rk[10], FIPS_RK10);
    applyStimulus(1'b1, FIPS_KEY, 1'b0, 4'd0);
    checkOutput("expand_busy",      128'(busy),      128'd1);
    checkOutput("expand_key_ready", 128'(key_ready), 128'd0);
    checkOutput("expand_sw_out",    128'(sw_out),    128'({FIPS_KEY[23:0], FIPS_KEY[31:24]}));
    lat = 1; bc = 0;
    for (int n = 0; n < 40 && !keys_ready; n++) begin
      if (busy) bc++;
      lat++;
      applyStimulus(n == 2, SEQ_KEY, n == 4, 4'd3);
      if (n == 4) checkOutput("expand_req_dropped", 128'(rk_valid), 128'd0);
    end
    checkOutput("fips_ready_latency", 128'(lat), 128'd11);
    checkOutput("fips_busy_cycles",   128'(bc),  128'd10);

    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, '0, 1'b1, tbl[i].idx);
      checkOutput($sformatf("tbl%0d_valid", i), 128'(rk_valid), 128'd1);
      checkOutput($sformatf("tbl%0d_err", i),   128'(rk_err),   128'(tbl[i].err));
      checkOutput($sformatf("tbl%0d_data", i),  rk_data,        tbl[i].data);
    end

    for (int i = 0; i <= 10; i++) readCheck(4'(i), $sformatf("sweep%0d", i));
    readCheck(4'd11, "sweep11");
    readCheck(4'd15, "sweep15");
    readCheck(4'd5, "hold_src");
    applyStimulus(1'b0, '0, 1'b0, 4'd0);
    checkOutput("no_req_valid", 128'(rk_valid), 128'd0);
    checkOutput("no_req_err",   128'(rk_err),   128'd0);
    checkOutput("no_req_hold",  rk_data,        model_rk[5]);

    // Reload in READY with a read of index 0 on the same edge.
    applyStimulus(1'b1, SEQ_KEY, 1'b1, 4'd0);
    checkOutput("collide_valid",      128'(rk_valid),   128'd1);
    checkOutput("collide_old_key",    rk_data,          FIPS_KEY);
    checkOutput("reload_keys_ready",  128'(keys_ready), 128'd0);
    checkOutput("reload_busy",        128'(busy),       128'd1);
    computeModel(SEQ_KEY);
    checkOutput("model_seq_rk10", model_rk[10], SEQ_RK10);
    waitReady(lat, bc);
    checkOutput("reload_latency", 128'(lat), 128'd11);
    readCheck(4'd10, "reload_rk10");
    readCheck(4'd0,  "reload_rk0");

    // Reset asserted during expand cycle 5.
    computeModel(FIPS_KEY);
    applyStimulus(1'b1, FIPS_KEY, 1'b0, 4'd0);
    repeat (4) applyStimulus(1'b0, '0, 1'b0, 4'd0);
    rst_n = 1'b0;
    #1;
    checkResetOutputs("midreset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    applyStimulus(1'b0, '0, 1'b0, 4'd0);
    checkResetOutputs("post_reset");
    applyStimulus(1'b0, '0, 1'b1, 4'd2);
    checkOutput("post_reset_req_dropped", 128'(rk_valid), 128'd0);
    applyStimulus(1'b1, FIPS_KEY, 1'b0, 4'd0);
    waitReady(lat, bc);
    checkOutput("fresh_latency", 128'(lat), 128'd11);
    readCheck(4'd1,  "fresh_rk1");
    readCheck(4'd10, "fresh_rk10");

    for (int iter = 0; iter < 15; iter++) begin
      rkey = {$urandom, $urandom, $urandom, $urandom};
      computeModel(rkey);
      applyStimulus(1'b1, rkey, 1'b0, 4'd0);
      waitReady(lat, bc);
      checkOutput($sformatf("rand%0d_latency", iter), 128'(lat), 128'd11);
      for (int j = 0; j < 8; j++) readCheck(4'($urandom_range(0, 15)), $sformatf("rand%0d_rd%0d", iter, j));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
